// File: rtl/cache_miss_controller.sv
// rtl/cache_miss_controller.sv - load/store sequencer between CPU port, 2-way cache and main memory
module cache_miss_controller #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    input  logic                  req_write_i,
    input  logic [DATA_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  stall_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    input  logic                  cache_hit_i,
    input  logic [DATA_WIDTH-1:0] cache_rdata_i,
    output logic [DATA_WIDTH-1:0] cache_addr_o,
    output logic [DATA_WIDTH-1:0] cache_wdata_o,
    output logic                  cache_fill_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_ready_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [CNT_WIDTH-1:0]  hit_count_o,
    output logic [CNT_WIDTH-1:0]  miss_count_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        FILL    = 3'd3,
        WR_REQ  = 3'd4,
        WR_UPD  = 3'd5,
        RESP    = 3'd6
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    hit_q;
    logic [CNT_WIDTH-1:0]    hit_cnt_q;
    logic [CNT_WIDTH-1:0]    miss_cnt_q;

    logic load_hit, load_miss, store_req;
    logic [DATA_WIDTH-1:0] mem_addr_aligned;

    assign load_hit  = (state_q == IDLE) && req_valid_i && !req_write_i && cache_hit_i;
    assign load_miss = (state_q == IDLE) && req_valid_i && !req_write_i && !cache_hit_i;
    assign store_req = (state_q == IDLE) && req_valid_i && req_write_i;

    assign mem_addr_aligned = {addr_q[DATA_WIDTH-1:2], 2'b00};
    assign hit_count_o      = hit_cnt_q;
    assign miss_count_o     = miss_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        stall_o       = 1'b1;
        rdata_o       = '0;
        cache_addr_o  = addr_q;
        cache_wdata_o = '0;
        cache_fill_o  = 1'b0;
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        mem_addr_o    = '0;
        mem_wdata_o   = '0;
        case (state_q)
            IDLE: begin
                cache_addr_o = req_addr_i;
                stall_o      = req_valid_i && (req_write_i || !cache_hit_i);
                if (load_hit) begin
                    rdata_o = cache_rdata_i;
                end
                if (load_miss) begin
                    state_d = RD_REQ;
                end else if (store_req) begin
                    state_d = WR_REQ;
                end
            end
            RD_REQ: begin
                mem_req_o  = 1'b1;
                mem_addr_o = mem_addr_aligned;
                if (mem_ready_i) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (mem_rvalid_i) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                cache_fill_o  = 1'b1;
                cache_wdata_o = data_q;
                state_d       = RESP;
            end
            WR_REQ: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = mem_addr_aligned;
                mem_wdata_o = wdata_q;
                if (mem_ready_i) begin
                    state_d = hit_q ? WR_UPD : RESP;
                end
            end
            WR_UPD: begin
                cache_fill_o  = 1'b1;
                cache_wdata_o = wdata_q;
                state_d       = RESP;
            end
            RESP: begin
                // CPU retires here; data_q is zero when the request was a store
                stall_o = 1'b0;
                rdata_o = data_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            hit_q   <= 1'b0;
        end else begin
            if (load_miss) begin
                addr_q <= req_addr_i;
            end
            if (store_req) begin
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                hit_q   <= cache_hit_i;
                data_q  <= '0;
            end
            if ((state_q == RD_WAIT) && mem_rvalid_i) begin
                data_q <= mem_rdata_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (load_hit && (hit_cnt_q != '1)) begin
                hit_cnt_q <= hit_cnt_q + CNT_ONE;
            end
            if (load_miss && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_cache_miss_controller.sv
// tb/tb_cache_miss_controller.sv - directed vector bench for cache_miss_controller
module tb_cache_miss_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_write, cache_hit, mem_ready, mem_rvalid;
    logic [31:0] req_addr, req_wdata, cache_rdata, mem_rdata;
    logic        stall, cache_fill, mem_req, mem_we;
    logic [31:0] rdata, cache_addr, cache_wdata, mem_addr, mem_wdata;
    logic [15:0] hit_count, miss_count;
    logic        s_stall, s_fill, s_mreq, s_mwe;
    logic [31:0] s_rdata, s_caddr, s_cwdata, s_maddr, s_mwdata;
    logic [1:0]  s_hitc, s_missc;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    cache_miss_controller #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .stall_o(stall), .rdata_o(rdata),
        .cache_hit_i(cache_hit), .cache_rdata_i(cache_rdata), .cache_addr_o(cache_addr),
        .cache_wdata_o(cache_wdata), .cache_fill_o(cache_fill),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_ready_i(mem_ready), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .hit_count_o(hit_count), .miss_count_o(miss_count)
    );

    cache_miss_controller #(.DATA_WIDTH(32), .CNT_WIDTH(2)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .stall_o(s_stall), .rdata_o(s_rdata),
        .cache_hit_i(cache_hit), .cache_rdata_i(cache_rdata), .cache_addr_o(s_caddr),
        .cache_wdata_o(s_cwdata), .cache_fill_o(s_fill),
        .mem_req_o(s_mreq), .mem_we_o(s_mwe), .mem_addr_o(s_maddr), .mem_wdata_o(s_mwdata),
        .mem_ready_i(mem_ready), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .hit_count_o(s_hitc), .miss_count_o(s_missc)
    );

    typedef struct {
        logic        v, w;
        logic [31:0] addr, wd;
        logic        hit;
        logic [31:0] crd;
        logic        rdy, rv;
        logic [31:0] mrd;
        logic        e_stall;
        logic [31:0] e_rdata, e_caddr;
        logic        e_fill;
        logic [31:0] e_cwd;
        logic        e_mreq, e_mwe;
        logic [31:0] e_maddr, e_mwd;
        logic [15:0] e_hitc, e_missc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, w, input logic [31:0] addr, wd, input logic hit, input logic [31:0] crd,
                       input logic rdy, rv, input logic [31:0] mrd,
                       input logic e_stall, input logic [31:0] e_rdata, e_caddr, input logic e_fill,
                       input logic [31:0] e_cwd, input logic e_mreq, e_mwe, input logic [31:0] e_maddr, e_mwd,
                       input logic [15:0] e_hitc, e_missc);
        vec_t t;
        t.v = v; t.w = w; t.addr = addr; t.wd = wd; t.hit = hit; t.crd = crd;
        t.rdy = rdy; t.rv = rv; t.mrd = mrd;
        t.e_stall = e_stall; t.e_rdata = e_rdata; t.e_caddr = e_caddr; t.e_fill = e_fill; t.e_cwd = e_cwd;
        t.e_mreq = e_mreq; t.e_mwe = e_mwe; t.e_maddr = e_maddr; t.e_mwd = e_mwd;
        t.e_hitc = e_hitc; t.e_missc = e_missc;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        else passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, w, input logic [31:0] addr, wd, input logic hit, input logic [31:0] crd,
                         input logic rdy, rv, input logic [31:0] mrd);
        req_valid = v; req_write = w; req_addr = addr; req_wdata = wd; cache_hit = hit; cache_rdata = crd;
        mem_ready = rdy; mem_rvalid = rv; mem_rdata = mrd;
    endtask

    task automatic check_all_zero(input string tag, input int idx);
        check({tag, "_stall"}, idx, {31'd0, stall}, 32'd0);
        check({tag, "_rdata"}, idx, rdata, 32'd0);
        check({tag, "_caddr"}, idx, cache_addr, 32'd0);
        check({tag, "_fill"}, idx, {31'd0, cache_fill}, 32'd0);
        check({tag, "_cwdata"}, idx, cache_wdata, 32'd0);
        check({tag, "_mreq"}, idx, {30'd0, mem_req, mem_we}, 32'd0);
        check({tag, "_maddr"}, idx, mem_addr, 32'd0);
        check({tag, "_mwdata"}, idx, mem_wdata, 32'd0);
        check({tag, "_hitc"}, idx, {16'd0, hit_count}, 32'd0);
        check({tag, "_missc"}, idx, {16'd0, miss_count}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // load hit, then idle
        add(1,0,32'h10,0,1,32'hDEADBEEF,0,0,0,  0,32'hDEADBEEF,32'h10,0,0,0,0,0,0, 0,0);
        add(0,0,0,0,0,0,0,0,0,                  0,0,0,0,0,0,0,0,0,                1,0);
        // load miss 0x24: ready after 2 cycles, rvalid 3 cycles later
        add(1,0,32'h24,0,0,32'hBAD,0,0,0,       1,0,32'h24,0,0,0,0,0,0,           1,0);
        add(1,0,32'h24,0,0,0,0,0,0,             1,0,32'h24,0,0,1,0,32'h24,0,      1,1);
        add(1,0,32'h24,0,0,0,1,0,0,             1,0,32'h24,0,0,1,0,32'h24,0,      1,1);
        add(1,0,32'h24,0,0,0,0,0,0,             1,0,32'h24,0,0,0,0,0,0,           1,1);
        add(1,0,32'h24,0,0,0,0,0,0,             1,0,32'h24,0,0,0,0,0,0,           1,1);
        add(1,0,32'h24,0,0,0,0,1,32'h12345678,  1,0,32'h24,0,0,0,0,0,0,           1,1);
        add(1,0,32'h24,0,0,0,0,0,0,             1,0,32'h24,1,32'h12345678,0,0,0,0, 1,1);
        add(1,0,32'h24,0,0,0,0,0,0,             0,32'h12345678,32'h24,0,0,0,0,0,0, 1,1);
        add(0,0,0,0,0,0,0,0,0,                  0,0,0,0,0,0,0,0,0,                1,1);
        // store hit 0x33
        add(1,1,32'h33,32'hA5A5A5A5,1,0,0,0,0,  1,0,32'h33,0,0,0,0,0,0,           1,1);
        add(1,1,32'h33,32'hA5A5A5A5,0,0,0,0,0,  1,0,32'h33,0,0,1,1,32'h30,32'hA5A5A5A5, 1,1);
        add(1,1,32'h33,32'hA5A5A5A5,0,0,1,0,0,  1,0,32'h33,0,0,1,1,32'h30,32'hA5A5A5A5, 1,1);
        add(1,1,32'h33,32'hA5A5A5A5,0,0,0,0,0,  1,0,32'h33,1,32'hA5A5A5A5,0,0,0,0, 1,1);
        add(1,1,32'h33,32'hA5A5A5A5,0,0,0,0,0,  0,0,32'h33,0,0,0,0,0,0,           1,1);
        // store miss 0x40: memory write only
        add(1,1,32'h40,32'h11112222,0,0,0,0,0,  1,0,32'h40,0,0,0,0,0,0,           1,1);
        add(1,1,32'h40,32'h11112222,1,0,1,0,0,  1,0,32'h40,0,0,1,1,32'h40,32'h11112222, 1,1);
        add(1,1,32'h40,32'h11112222,1,0,0,0,0,  0,0,32'h40,0,0,0,0,0,0,           1,1);
        add(0,0,0,0,0,0,0,0,0,                  0,0,0,0,0,0,0,0,0,                1,1);
        // minimum-latency miss: stall for exactly 4 cycles
        add(1,0,32'h52,0,0,0,1,1,32'h0BADF00D,  1,0,32'h52,0,0,0,0,0,0,           1,1);
        add(1,0,32'h52,0,0,0,1,1,32'h0BADF00D,  1,0,32'h52,0,0,1,0,32'h50,0,      1,2);
        add(1,0,32'h52,0,0,0,1,1,32'hCAFEF00D,  1,0,32'h52,0,0,0,0,0,0,           1,2);
        add(1,0,32'h52,0,0,0,1,1,32'h0BADF00D,  1,0,32'h52,1,32'hCAFEF00D,0,0,0,0, 1,2);
        add(1,0,32'h52,0,0,0,1,1,32'h0BADF00D,  0,32'hCAFEF00D,32'h52,0,0,0,0,0,0, 1,2);
        // stray rvalid in IDLE is ignored
        add(0,0,0,0,0,0,0,1,32'h999,            0,0,0,0,0,0,0,0,0,                1,2);
        add(0,0,0,0,0,0,0,0,0,                  0,0,0,0,0,0,0,0,0,                1,2);

        step();
        step();
        check_all_zero("reset", 0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step();
            drive(vecs[i].v, vecs[i].w, vecs[i].addr, vecs[i].wd, vecs[i].hit, vecs[i].crd,
                  vecs[i].rdy, vecs[i].rv, vecs[i].mrd);
            #3;
            check("stall", i, {31'd0, stall}, {31'd0, vecs[i].e_stall});
            check("rdata", i, rdata, vecs[i].e_rdata);
            check("cache_addr", i, cache_addr, vecs[i].e_caddr);
            check("cache_fill", i, {31'd0, cache_fill}, {31'd0, vecs[i].e_fill});
            check("cache_wdata", i, cache_wdata, vecs[i].e_cwd);
            check("mem_req", i, {31'd0, mem_req}, {31'd0, vecs[i].e_mreq});
            check("mem_we", i, {31'd0, mem_we}, {31'd0, vecs[i].e_mwe});
            check("mem_addr", i, mem_addr, vecs[i].e_maddr);
            check("mem_wdata", i, mem_wdata, vecs[i].e_mwd);
            check("hit_count", i, {16'd0, hit_count}, {16'd0, vecs[i].e_hitc});
            check("miss_count", i, {16'd0, miss_count}, {16'd0, vecs[i].e_missc});
        end

        // reset asserted in RD_WAIT, followed by a stray rvalid
        step();
        drive(1, 0, 32'h60, 0, 0, 0, 1, 0, 0);
        step();
        step();
        drive(1, 0, 32'h60, 0, 0, 0, 0, 0, 0);
        #3;
        check("rdwait_stall", 0, {31'd0, stall}, 32'd1);
        check("rdwait_mreq", 0, {31'd0, mem_req}, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset", 0);
        step();
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h77);
        for (int i = 1; i <= 3; i++) begin
            step();
            #3;
            check_all_zero("stray_rvalid", i);
        end
        mem_rvalid = 1'b0;

        // 5 load hits: CNT_WIDTH=2 instance saturates at 3
        for (int i = 0; i < 5; i++) begin
            step();
            drive(1, 0, 32'h80, 0, 1, 32'h100 + i, 0, 0, 0);
            #3;
            check("sat_stall", i, {31'd0, stall}, 32'd0);
            check("sat_rdata", i, rdata, 32'h100 + i);
            check("sat_hitc", i, {30'd0, s_hitc}, (i < 3) ? i : 3);
        end
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        check("sat_hitc_final", 5, {30'd0, s_hitc}, 32'd3);
        check("dut_hitc_final", 5, {16'd0, hit_count}, 32'd5);
        check("sat_missc_final", 5, {30'd0, s_missc}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cache_miss_controller.md
Name: cache_miss_controller

Overview:
Sequencer between the CPU load/store port, the two-way associative cache and the main-memory port. Read hits complete combinationally with no stall. On a read miss it stalls the CPU, fetches the word from memory and fills the cache. Stores are write-through and no-write-allocate. It also keeps saturating hit and miss counters for performance measurement.

Parameters:
DATA_WIDTH, 32, width of address, data and memory buses
CNT_WIDTH, 16, width of hit/miss counters (saturating)

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
req_valid_i  in  1  CPU memory request present
req_write_i  in  1  1 = store, 0 = load
req_addr_i  in  DATA_WIDTH  byte address; bits [1:0] ignored
req_wdata_i  in  DATA_WIDTH  store data
stall_o  out  1  CPU must hold the request and freeze
rdata_o  out  DATA_WIDTH  load result
cache_hit_i  in  1  cache hit for cache_addr_o
cache_rdata_i  in  DATA_WIDTH  cache read data
cache_addr_o  out  DATA_WIDTH  address driven to cache
cache_wdata_o  out  DATA_WIDTH  fill/update data to cache
cache_fill_o  out  1  cache write strobe (cache samples on negedge)
mem_req_o  out  1  memory request valid
mem_we_o  out  1  memory write enable
mem_addr_o  out  DATA_WIDTH  word-aligned address ({addr[31:2],2'b00})
mem_wdata_o  out  DATA_WIDTH  memory write data
mem_ready_i  in  1  memory accepts the request this cycle
mem_rvalid_i  in  1  memory read data valid
mem_rdata_i  in  DATA_WIDTH  memory read data
hit_count_o  out  CNT_WIDTH  load hits
miss_count_o  out  CNT_WIDTH  load misses

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all registers, counters and outputs are 0.
  - Reset mid-transaction abandons it; any later mem_rvalid_i is ignored in IDLE.
- Address muxing: cache_addr_o = req_addr_i in IDLE, else the latched address addr_q.
- States IDLE, RD_REQ, RD_WAIT, FILL, WR_REQ, WR_UPD, RESP. stall_o=1 in every state except IDLE and RESP.
- IDLE:
  - !req_valid_i: stay in IDLE.
  - Load hit: rdata_o=cache_rdata_i (combinational), stall_o=0, hit_count++, stay in IDLE.
  - Load miss: stall_o=1 in that same cycle; latch addr_q; miss_count++; go to RD_REQ.
  - Store: stall_o=1; latch addr_q, wdata_q and hit_q=cache_hit_i; go to WR_REQ.
- RD_REQ: mem_req_o=1, mem_we_o=0, mem_addr_o=addr_q. Hold until mem_ready_i=1 is sampled, then go to RD_WAIT. If mem_ready_i is already 1 in the first cycle, RD_REQ lasts exactly 1 cycle.
- RD_WAIT: mem_req_o=0. When mem_rvalid_i=1, capture data_q=mem_rdata_i and go to FILL. No timeout; waits indefinitely.
- FILL: cache_fill_o=1 for exactly 1 cycle, cache_wdata_o=data_q; then go to RESP.
- WR_REQ: mem_req_o=1, mem_we_o=1, mem_wdata_o=wdata_q. On mem_ready_i, go to WR_UPD if hit_q=1, else RESP.
- WR_UPD: cache_fill_o=1, cache_wdata_o=wdata_q, 1 cycle; then go to RESP. Keeps the cache coherent with memory.
- RESP:
  - stall_o=0; rdata_o=data_q (after a load) or 0 (after a store).
  - The CPU retires the request on this edge. The controller does not evaluate req_valid_i in RESP; it goes to IDLE unconditionally next cycle.
- Minimum miss latency with mem_ready_i and mem_rvalid_i returned immediately: IDLE→RD_REQ→RD_WAIT→FILL→RESP = stall high for 4 cycles.
- mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o stay stable while waiting for mem_ready_i.
- Counters: saturate at all-ones with no wrap. Stores do not count.
- mem_rvalid_i outside RD_WAIT is ignored. cache_fill_o is never asserted outside FILL and WR_UPD.

Test Plan:
- Load 0x0000_0010 with cache_hit_i=1, cache_rdata_i=0xDEADBEEF → same cycle rdata_o=0xDEADBEEF, stall_o=0; hit_count_o=1 next cycle.
- Load 0x0000_0024 miss; mem_ready_i after 2 cycles, mem_rvalid_i 3 cycles later with 0x12345678 → mem_addr_o=0x24 held stable, then 1-cycle cache_fill_o with wdata 0x12345678, RESP rdata_o=0x12345678, miss_count_o=1.
- Store 0x0000_0033 data 0xA5A5A5A5 with cache_hit_i=1 → mem_addr_o=0x30, mem_we_o=1 until mem_ready_i, then 1-cycle cache_fill_o with 0xA5A5A5A5, RESP; counters unchanged.
- Store that misses → memory write only; cache_fill_o stays 0 throughout.
- rst_n low during RD_WAIT, then a stray mem_rvalid_i after release → all outputs 0, state IDLE, no cache_fill_o, counters 0.
- CNT_WIDTH=2, 5 consecutive load hits → hit_count_o saturates at 3.
